// File: rtl/serial_tofed_tx.sv
// Serial TOFED transmitter: encodes a decimal digit into a 3-of-5 codeword
// and shifts it out MSB-first, with an optional idle gap between frames.
module serial_tofed_tx #(
    parameter int unsigned GAP = 0
) (
    input  logic        clk,
    input  logic        resetH,
    input  logic [3:0]  digit,
    input  logic        load,
    output logic        ready,
    output logic        dout,
    output logic        frame_start,
    output logic        busy,
    output logic        err,
    output logic [15:0] frames_sent
);

    typedef enum logic [1:0] {StIdle, StShift, StGap} state_e;

    localparam bit         HasGap  = (GAP != 0);
    localparam logic [3:0] GapLast = 4'(HasGap ? GAP - 1 : 0);

    state_e      state_q, state_d;
    logic [4:0]  shreg_q, shreg_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [3:0]  gap_cnt_q, gap_cnt_d;
    logic [15:0] frames_sent_q, frames_sent_d;
    logic        dout_q, dout_d;
    logic        frame_start_q, frame_start_d;
    logic        busy_q, busy_d;
    logic        err_q, err_d;
    logic        transfer;
    logic        digit_ok;

    // Codebook, MSB first; out-of-range digits never reach the shifter.
    function automatic logic [4:0] encode(input logic [3:0] d);
        case (d)
            4'd0:    encode = 5'b11100;
            4'd1:    encode = 5'b11010;
            4'd2:    encode = 5'b11001;
            4'd3:    encode = 5'b10110;
            4'd4:    encode = 5'b10101;
            4'd5:    encode = 5'b10011;
            4'd6:    encode = 5'b01110;
            4'd7:    encode = 5'b01101;
            4'd8:    encode = 5'b01011;
            4'd9:    encode = 5'b00111;
            default: encode = 5'b00000;
        endcase
    endfunction

    // Accept in IDLE, or on the last bit of a frame when frames run back-to-back.
    assign ready = resetH && ((state_q == StIdle) ||
                   ((state_q == StShift) && (bit_cnt_q == 3'd4) && !HasGap));

    assign transfer = load && ready;
    assign digit_ok = (digit <= 4'd9);

    // Next-state, datapath updates and registered-output precompute.
    always_comb begin
        state_d       = state_q;
        shreg_d       = shreg_q;
        bit_cnt_d     = bit_cnt_q;
        gap_cnt_d     = gap_cnt_q;
        frames_sent_d = frames_sent_q;
        err_d         = transfer && !digit_ok;

        case (state_q)
            StIdle: begin
                if (transfer && digit_ok) begin
                    state_d   = StShift;
                    shreg_d   = encode(digit);
                    bit_cnt_d = 3'd0;
                end
            end
            StShift: begin
                if (bit_cnt_q == 3'd4) begin
                    frames_sent_d = frames_sent_q + 16'd1;
                    if (HasGap) begin
                        state_d   = StGap;
                        gap_cnt_d = 4'd0;
                    end else if (transfer && digit_ok) begin
                        shreg_d   = encode(digit);
                        bit_cnt_d = 3'd0;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    // Rotate rather than shift so every stored bit stays live.
                    shreg_d   = {shreg_q[3:0], shreg_q[4]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                end
            end
            StGap: begin
                if (gap_cnt_q == GapLast) begin
                    state_d = StIdle;
                end else begin
                    gap_cnt_d = gap_cnt_q + 4'd1;
                end
            end
            default: state_d = StIdle;
        endcase

        dout_d        = (state_d == StShift) && shreg_d[4];
        frame_start_d = (state_d == StShift) && (bit_cnt_d == 3'd0);
        busy_d        = (state_d != StIdle);
    end

    // State and output registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge resetH) begin
        if (!resetH) begin
            state_q       <= StIdle;
            shreg_q       <= 5'd0;
            bit_cnt_q     <= 3'd0;
            gap_cnt_q     <= 4'd0;
            frames_sent_q <= 16'd0;
            dout_q        <= 1'b0;
            frame_start_q <= 1'b0;
            busy_q        <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            shreg_q       <= shreg_d;
            bit_cnt_q     <= bit_cnt_d;
            gap_cnt_q     <= gap_cnt_d;
            frames_sent_q <= frames_sent_d;
            dout_q        <= dout_d;
            frame_start_q <= frame_start_d;
            busy_q        <= busy_d;
            err_q         <= err_d;
        end
    end

    assign dout        = dout_q;
    assign frame_start = frame_start_q;
    assign busy        = busy_q;
    assign err         = err_q;
    assign frames_sent = frames_sent_q;

endmodule

// File: tb/tb_serial_tofed_tx.sv
// Bench for serial_tofed_tx: one instance with no gap, one with GAP = 3.
module tb_serial_tofed_tx;

    logic        clk;
    logic        resetH;
    logic [3:0]  digit0, digit3;
    logic        load0, load3;
    logic        ready0, ready3;
    logic        dout0, dout3;
    logic        fs0, fs3;
    logic        busy0, busy3;
    logic        err0, err3;
    logic [15:0] fr0, fr3;

    int          total = 0;
    int          bad = 0;
    int          digq[$];
    logic [15:0] sent0 = 16'd0;
    logic [15:0] sent3 = 16'd0;

    serial_tofed_tx #(.GAP(0)) dut0 (
        .clk(clk), .resetH(resetH), .digit(digit0), .load(load0), .ready(ready0),
        .dout(dout0), .frame_start(fs0), .busy(busy0), .err(err0), .frames_sent(fr0)
    );

    serial_tofed_tx #(.GAP(3)) dut3 (
        .clk(clk), .resetH(resetH), .digit(digit3), .load(load3), .ready(ready3),
        .dout(dout3), .frame_start(fs3), .busy(busy3), .err(err3), .frames_sent(fr3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [4:0] book(input int d);
        case (d)
            0: book = 5'b11100;  1: book = 5'b11010;  2: book = 5'b11001;
            3: book = 5'b10110;  4: book = 5'b10101;  5: book = 5'b10011;
            6: book = 5'b01110;  7: book = 5'b01101;  8: book = 5'b01011;
            default: book = 5'b00111;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Send every digit in digq with load held high, comparing each cycle to the
    // frame/gap/idle timeline. Entered and left at a negedge with the DUT idle.
    task automatic run_stream(input bit sel, input int n);
        int          g, per, k, q, done, ones;
        bit          in_frame;
        logic [4:0]  cw;
        logic        e_dout, e_fs, e_busy, e_rdy;
        logic        o_dout, o_fs, o_busy, o_rdy, o_err;
        logic [15:0] base, e_fr, o_fr;
        g    = sel ? 3 : 0;
        per  = 5 + g + ((g > 0) ? 1 : 0);
        base = sel ? sent3 : sent0;
        ones = 0;
        for (int c = 0; c <= n * per + 1; c++) begin
            e_dout = 1'b0; e_fs = 1'b0; e_busy = 1'b0; e_rdy = 1'b1;
            in_frame = 1'b0; k = n; q = 0;
            if (c >= 1) begin
                k = (c - 1) / per;
                q = (c - 1) % per;
                if (k < n) begin
                    cw = book(digq[k]);
                    if (q < 5) begin
                        in_frame = 1'b1;
                        e_dout = cw[4 - q];
                        e_fs   = (q == 0);
                        e_busy = 1'b1;
                        e_rdy  = (g == 0) && (q == 4);
                    end else if (q < 5 + g) begin
                        e_busy = 1'b1;
                        e_rdy  = 1'b0;
                    end
                end
            end
            done = 0;
            for (int j = 0; j < n; j++) if (j * per + 6 <= c) done++;
            e_fr = base + 16'(done);

            o_dout = sel ? dout3 : dout0;
            o_fs   = sel ? fs3 : fs0;
            o_busy = sel ? busy3 : busy0;
            o_rdy  = sel ? ready3 : ready0;
            o_err  = sel ? err3 : err0;
            o_fr   = sel ? fr3 : fr0;
            chk("dout", 32'(o_dout), 32'(e_dout));
            chk("frame_start", 32'(o_fs), 32'(e_fs));
            chk("busy", 32'(o_busy), 32'(e_busy));
            chk("ready", 32'(o_rdy), 32'(e_rdy));
            chk("err_quiet", 32'(o_err), 32'd0);
            chk("frames_sent", 32'(o_fr), 32'(e_fr));
            ones = o_fs ? int'(o_dout) : ones + int'(o_dout);
            if (in_frame && q == 4) chk("three_ones", 32'(ones), 32'd3);

            if (c / per < n) begin
                if (sel) begin load3 = 1'b1; digit3 = 4'(digq[c / per]); end
                else     begin load0 = 1'b1; digit0 = 4'(digq[c / per]); end
            end else begin
                load0 = 1'b0; load3 = 1'b0; digit0 = 4'd0; digit3 = 4'd0;
            end
            @(negedge clk);
        end
        load0 = 1'b0; load3 = 1'b0;
        if (sel) sent3 = sent3 + 16'(n);
        else     sent0 = sent0 + 16'(n);
    endtask

    initial begin
        int d;
        resetH = 1'b1;
        digit0 = 4'd0; digit3 = 4'd0; load0 = 1'b0; load3 = 1'b0;
        #2 resetH = 1'b0;
        #1;
        chk("rst_dout", 32'(dout0), 32'd0);
        chk("rst_fs", 32'(fs0), 32'd0);
        chk("rst_busy", 32'(busy0), 32'd0);
        chk("rst_err", 32'(err0), 32'd0);
        chk("rst_ready", 32'(ready0), 32'd0);
        chk("rst_frames", 32'(fr0), 32'd0);
        chk("rst_ready_g3", 32'(ready3), 32'd0);
        @(negedge clk);
        @(negedge clk);
        resetH = 1'b1;
        #1;
        chk("post_rst_ready", 32'(ready0), 32'd1);
        chk("post_rst_ready_g3", 32'(ready3), 32'd1);
        @(negedge clk);

        // Single frame of digit 4.
        digq = {4};
        run_stream(1'b0, 1);

        // Digits 0..9 back-to-back, then a random stream.
        digq = {0, 1, 2, 3, 4, 5, 6, 7, 8, 9};
        run_stream(1'b0, 10);
        digq = {};
        for (int i = 0; i < 20; i++) digq.push_back(int'($urandom_range(0, 9)));
        run_stream(1'b0, 20);

        // Out-of-range digits accepted in IDLE.
        for (int i = 0; i < 4; i++) begin
            d = (i == 0) ? 12 : int'($urandom_range(10, 15));
            chk("err_pre_ready", 32'(ready0), 32'd1);
            load0 = 1'b1; digit0 = 4'(d);
            @(negedge clk);
            load0 = 1'b0; digit0 = 4'd0;
            chk("err_pulse", 32'(err0), 32'd1);
            chk("err_dout", 32'(dout0), 32'd0);
            chk("err_ready", 32'(ready0), 32'd1);
            chk("err_busy", 32'(busy0), 32'd0);
            chk("err_frames", 32'(fr0), 32'(sent0));
            @(negedge clk);
            chk("err_one_cycle", 32'(err0), 32'd0);
            chk("err_dout2", 32'(dout0), 32'd0);
        end

        // Bad digit offered on the last bit of a frame: frame counts, no reload.
        load0 = 1'b1; digit0 = 4'd3;
        @(negedge clk);
        digit0 = 4'd13;
        for (int i = 0; i < 4; i++) @(negedge clk);
        chk("bit4_ready", 32'(ready0), 32'd1);
        @(negedge clk);
        load0 = 1'b0; digit0 = 4'd0;
        sent0 = sent0 + 16'd1;
        chk("bit4_err", 32'(err0), 32'd1);
        chk("bit4_busy", 32'(busy0), 32'd0);
        chk("bit4_dout", 32'(dout0), 32'd0);
        chk("bit4_frames", 32'(fr0), 32'(sent0));
        @(negedge clk);
        chk("bit4_err_clear", 32'(err0), 32'd0);

        // GAP = 3: 7 then 2, then a short random run.
        digq = {7, 2};
        run_stream(1'b1, 2);
        digq = {};
        for (int i = 0; i < 6; i++) digq.push_back(int'($urandom_range(0, 9)));
        run_stream(1'b1, 6);

        // Asynchronous reset during bit 2 of digit 5.
        load0 = 1'b1; digit0 = 4'd5;
        @(negedge clk);
        load0 = 1'b0; digit0 = 4'd0;
        @(negedge clk);
        @(negedge clk);
        chk("abort_busy", 32'(busy0), 32'd1);
        #2 resetH = 1'b0;
        #1;
        chk("abort_dout", 32'(dout0), 32'd0);
        chk("abort_busy_low", 32'(busy0), 32'd0);
        chk("abort_ready", 32'(ready0), 32'd0);
        chk("abort_frames", 32'(fr0), 32'd0);
        chk("abort_frames_g3", 32'(fr3), 32'd0);
        @(negedge clk);
        resetH = 1'b1;
        sent0 = 16'd0;
        sent3 = 16'd0;
        #1;
        chk("abort_release_ready", 32'(ready0), 32'd1);
        @(negedge clk);
        digq = {9};
        run_stream(1'b0, 1);

        // Counter wrap.
        force dut0.frames_sent_q = 16'hffff;
        @(negedge clk);
        release dut0.frames_sent_q;
        sent0 = 16'hffff;
        chk("wrap_preload", 32'(fr0), 32'h0000ffff);
        digq = {int'($urandom_range(0, 9))};
        run_stream(1'b0, 1);
        chk("wrap_zero", 32'(fr0), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
